// File: rtl/shift_uart_tx_if.sv
// shift_uart_tx_if: valid/ready word handshake between a parallel producer and the serial transmitter
interface shift_uart_tx_if #(parameter int WIDTH = 8);
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  modport master (output tx_valid, tx_data, input tx_ready);
  modport slave  (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/shift_uart_tx.sv
// shift_uart_tx: frames a parallel word as start bit, WIDTH data bits LSB first, stop bit, on a registered serial line
module shift_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  shift_uart_tx_if.slave  tx,
  output logic            tx_serial,
  output logic            tx_busy,
  output logic            tx_done
);
  localparam int BAUD_W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [BIT_W-1:0]  r_bit;
  logic [BAUD_W-1:0] r_baud;
  logic              r_serial, r_ready, r_busy, r_done;
  logic              w_bit_end, w_last;
  logic [WIDTH-1:0]  w_shift_next;
  assign w_bit_end    = r_baud == BAUD_W'(CLKS_PER_BIT - 1);
  assign w_last       = r_bit == BIT_W'(WIDTH - 1);
  assign w_shift_next = r_shift >> 1;
  assign tx.tx_ready  = r_ready;
  assign tx_serial    = r_serial;
  assign tx_busy      = r_busy;
  assign tx_done      = r_done;
  // Line level is registered alongside the state so it changes only on clock edges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_baud   <= '0;
      r_serial <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (tx.tx_valid) begin
          r_state  <= S_START;
          r_shift  <= tx.tx_data;
          r_baud   <= '0;
          r_serial <= 1'b0;
          r_ready  <= 1'b0;
          r_busy   <= 1'b1;
        end
        S_START: if (w_bit_end) begin
          r_state  <= S_DATA;
          r_baud   <= '0;
          r_bit    <= '0;
          r_serial <= r_shift[0];
        end else r_baud <= r_baud + 1'b1;
        S_DATA: if (w_bit_end) begin
          r_baud <= '0;
          if (w_last) begin
            r_state  <= S_STOP;
            r_serial <= 1'b1;
          end else begin
            r_shift  <= w_shift_next;
            r_bit    <= r_bit + 1'b1;
            r_serial <= w_shift_next[0];
          end
        end else r_baud <= r_baud + 1'b1;
        S_STOP: if (w_bit_end) begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else r_baud <= r_baud + 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_uart_tx.sv
// tb_shift_uart_tx: directed and randomized frames on two transmitter configurations checked against a per-cycle frame model
module tb_shift_uart_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  shift_uart_tx_if #(.WIDTH(8)) if0 ();
  shift_uart_tx_if #(.WIDTH(4)) if1 ();
  logic ser0, busy0, done0, ser1, busy1, done1;
  shift_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .reset(reset), .tx(if0), .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0));
  shift_uart_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .tx(if1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1));
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cyc = 0;
  int t1;
  always @(posedge clk) cyc++;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Expected line level k cycles after the acceptance edge, from the frame layout alone
  function automatic logic exp_line(logic [31:0] w, int wd, int c, int k);
    if (k <= c) return 1'b0;
    if (k <= (wd + 1) * c) return w[(k - c - 1) / c];
    return 1'b1;
  endfunction
  function automatic logic o_line(int sel);  return sel != 0 ? ser1 : ser0; endfunction
  function automatic logic o_busy(int sel);  return sel != 0 ? busy1 : busy0; endfunction
  function automatic logic o_done(int sel);  return sel != 0 ? done1 : done0; endfunction
  function automatic logic o_ready(int sel); return sel != 0 ? if1.tx_ready : if0.tx_ready; endfunction
  task automatic drive(int sel, logic v, logic [31:0] d);
    if (sel != 0) begin
      if1.tx_valid = v;
      if1.tx_data  = d[3:0];
    end else begin
      if0.tx_valid = v;
      if0.tx_data  = d[7:0];
    end
  endtask
  task automatic idle_chk(int sel);
    @(posedge clk); #1;
    chk("idle_line", o_line(sel), 1);
    chk("idle_busy", o_busy(sel), 0);
    chk("idle_ready", o_ready(sel), 1);
    chk("idle_done", o_done(sel), 0);
  endtask
  // Sends one word; returns in the tx_done cycle (or two cycles after an abort reset)
  task automatic frame(int sel, logic [31:0] word, bit perturb, int abort);
    int wd;
    int c;
    int n;
    wd = sel != 0 ? 4 : 8;
    c  = sel != 0 ? 1 : 4;
    n  = (wd + 2) * c;
    drive(sel, 1'b1, word);
    @(posedge clk); #1;
    drive(sel, 1'b0, perturb ? $urandom : word);
    for (int k = 1; k <= n + 1; k++) begin
      chk("line", o_line(sel), exp_line(word, wd, c, k));
      chk("ready", o_ready(sel), k > n);
      chk("busy", o_busy(sel), k <= n);
      chk("done", o_done(sel), k == n + 1);
      if (k == n + 1) done_cyc = cyc;
      if (k == abort) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_line", o_line(sel), 1);
        chk("rst_ready", o_ready(sel), 1);
        chk("rst_busy", o_busy(sel), 0);
        chk("rst_done", o_done(sel), 0);
        @(posedge clk); #1;
        chk("rst_done2", o_done(sel), 0);
        chk("rst_line2", o_line(sel), 1);
        return;
      end
      if (k <= n) begin
        if (perturb && k == c + 2) drive(sel, 1'b1, 32'h3C);
        else if (perturb && k < n) drive(sel, 1'($urandom_range(0, 1)), $urandom);
        else drive(sel, 1'b0, $urandom);
        @(posedge clk); #1;
      end
    end
    drive(sel, 1'b0, $urandom);
  endtask
  initial begin
    drive(0, 1'b1, 32'hA5);
    drive(1, 1'b1, 32'h6);
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_line", ser0, 1);
      chk("reset_ready", if0.tx_ready, 1);
      chk("reset_busy", busy0, 0);
      chk("reset_done", done0, 0);
      chk("reset_busy1", busy1, 0);
    end
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    reset = 1'b0;
    idle_chk(0);
    idle_chk(1);
    frame(0, 32'hA5, 1'b0, 0);
    idle_chk(0);
    frame(0, 32'h00, 1'b0, 0);
    t1 = done_cyc;
    frame(0, 32'hFF, 1'b0, 0);
    chk("b2b_gap", done_cyc - t1, 41);
    idle_chk(0);
    frame(0, 32'h5A, 1'b1, 0);
    idle_chk(0);
    idle_chk(0);
    frame(0, 32'hC3, 1'b0, 18);
    frame(0, 32'h81, 1'b0, 0);
    idle_chk(0);
    frame(1, 32'h6, 1'b0, 0);
    idle_chk(1);
    repeat (6) begin
      frame(0, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 0);
      idle_chk(0);
    end
    repeat (6) begin
      frame(1, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 0);
      idle_chk(1);
    end
    frame(1, 32'h9, 1'b0, 3);
    frame(1, 32'hA, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_uart_tx.md
Name: shift_uart_tx

Overview:
- Serial transmitter: accepts a parallel word through a valid/ready handshake and shifts it out on one line as a framed serial stream: start bit 0, WIDTH data bits LSB first, stop bit 1.
- It is the transmitting end of the team's flip-flop-built serial-in receiver.
- Sits between a parallel producer (counter, controller FSM) and the serial line.

Parameters:
WIDTH, 8, number of data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on the line (>=1)

Ports:
clk  input  1  rising-edge clock; the block's only clock
reset  input  1  synchronous, active-high reset; sampled on rising clk edge
tx_valid  input  1  producer has a word on tx_data
tx_data  input  WIDTH  parallel word to send; sampled only on acceptance edge
tx_ready  output  1  block can accept a word this cycle
tx_serial  output  1  serial line; idle level 1
tx_busy  output  1  frame in progress (START, DATA or STOP state)
tx_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (synchronous, active-high):
  - Reset dominates all other inputs in the same edge.
  - State is IDLE; tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register, bit counter and baud counter are all cleared.
- FSM has four states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_ready=1, tx_serial=1, tx_busy=0.
  - On an edge with tx_valid=1: latch tx_data into the shift register, go to START, clear the baud counter.
  - That edge is acceptance edge E0.
- START:
  - tx_serial=0 for exactly CLKS_PER_BIT cycles (cycles 1..C after E0).
  - Then go to DATA with bit counter = 0.
- DATA:
  - tx_serial = shift register bit 0.
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the bit counter increments.
  - After bit WIDTH-1 has been held, go to STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - On the edge ending the stop bit, go to IDLE.
- Frame completion:
  - The first IDLE cycle after STOP is cycle (WIDTH+2)*C+1 counted from E0.
  - In that cycle tx_done=1 (for exactly one cycle) and tx_ready=1.
- Outputs are registered (Moore): tx_serial changes only on clk edges, so there are no glitches.
- tx_ready=0 and tx_busy=1 in every cycle from the cycle after E0 through the last stop-bit cycle.
- Ignored inputs:
  - tx_valid while tx_ready=0 is ignored and not queued.
  - tx_data changes after E0 do not affect the frame in flight.
- Back-to-back frames:
  - tx_valid=1 during the tx_done cycle is accepted on that edge.
  - The next start bit begins the following cycle.
  - Minimum frame period is (WIDTH+2)*C+1 cycles; the line stays high for exactly that one idle cycle.
- Counter widths:
  - Baud counter wide enough for CLKS_PER_BIT-1; bit counter wide enough for WIDTH-1.
  - Neither counter may wrap mid-bit.
- CLKS_PER_BIT=1: each bit is held one cycle; frame = WIDTH+2 cycles plus one idle cycle.
- Reset mid-frame: on the next edge, line=1 and all outputs return to reset values; no tx_done pulse; the partial frame is abandoned.
- Reset and tx_valid on the same edge: reset wins; the word is not accepted.

Test Plan:
- Reset: hold reset 2 cycles with tx_valid=1 -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0; no frame starts.
- Single frame, WIDTH=8, C=4, tx_data=8'hA5:
  - Line sequence, each level 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
  - tx_done=1 only in cycle 41 after E0.
  - tx_ready=0 in cycles 1..40.
- Back-to-back: send 8'h00, then assert tx_valid with 8'hFF in the tx_done cycle -> exactly one idle-high cycle, then frame 0 | 1×8 | 1; two tx_done pulses 41 cycles apart.
- Ignored inputs: pulse tx_valid with 8'h3C during DATA and change tx_data mid-frame -> transmitted frame unchanged; no second frame follows.
- Reset mid-frame: assert reset during data bit 3 -> next cycle tx_serial=1, tx_ready=1, no tx_done; a new 8'h81 frame afterwards transmits correctly.
- C=1, WIDTH=4, tx_data=4'b0110: line 0,0,1,1,0,1 over 6 consecutive cycles; tx_done in cycle 7.
